// File: rtl/axis_route_stamp_pkg.sv
// Shared types and constants for the per-region route stamping ingress stage.
//   N_REGIONS      : default number of vFPGA regions (switch has 2*N_REGIONS ports)
//   ROUTE_BITS     : route / tdest width
//   ROUTE_DEST_*   : location of the destination port field inside a route
//   route_t        : route word
//   stamp_state_t  : packet FSM states
//   route_dest()   : extracts the destination port field of a route
package axis_route_stamp_pkg;

  localparam int N_REGIONS       = 6;
  localparam int ROUTE_BITS      = 14;
  localparam int ROUTE_DEST_MSB  = 13;
  localparam int ROUTE_DEST_LSB  = 10;
  localparam int ROUTE_DEST_BITS = ROUTE_DEST_MSB - ROUTE_DEST_LSB + 1;

  typedef logic [ROUTE_BITS-1:0] route_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PASS = 2'd1,
    DROP = 2'd2
  } stamp_state_t;

  function automatic logic [ROUTE_DEST_BITS-1:0] route_dest(input route_t route);
    return route[ROUTE_DEST_MSB:ROUTE_DEST_LSB];
  endfunction

endpackage

// File: rtl/axis_skid_reg.sv
// Two-entry skid buffer for a generic stream payload.
// Output is fully registered (1-cycle latency); s_ready is a register so the
// upstream ready never depends combinationally on m_ready.
// Ports:
//   aclk, aresetn      : clock, synchronous active-low reset
//   s_valid/s_ready    : upstream handshake, s_data payload (W bits)
//   m_valid/m_ready    : downstream handshake, m_data payload (W bits)
module axis_skid_reg #(
  parameter int W = 8
) (
  input  logic         aclk,
  input  logic         aresetn,
  input  logic         s_valid,
  output logic         s_ready,
  input  logic [W-1:0] s_data,
  output logic         m_valid,
  input  logic         m_ready,
  output logic [W-1:0] m_data
);

  logic         r_out_valid;
  logic         r_skid_valid;
  logic         r_s_ready;
  logic [W-1:0] r_out_data;
  logic [W-1:0] r_skid_data;

  logic w_s_fire;
  logic w_out_free;
  logic w_out_valid_next;
  logic w_skid_valid_next;
  logic w_load_out_from_skid;
  logic w_load_out_from_in;
  logic w_load_skid;

  assign w_s_fire   = s_valid && r_s_ready;
  // Output stage can take a new beat when empty or being drained this cycle.
  assign w_out_free = !r_out_valid || m_ready;

  always_comb begin
    w_load_out_from_skid = 1'b0;
    w_load_out_from_in   = 1'b0;
    w_load_skid          = 1'b0;
    w_out_valid_next     = r_out_valid;
    w_skid_valid_next    = r_skid_valid;
    if (w_out_free) begin
      // A full skid entry implies s_ready was low, so no new beat competes.
      if (r_skid_valid) begin
        w_load_out_from_skid = 1'b1;
        w_out_valid_next     = 1'b1;
        w_skid_valid_next    = 1'b0;
      end else if (w_s_fire) begin
        w_load_out_from_in = 1'b1;
        w_out_valid_next   = 1'b1;
      end else begin
        w_out_valid_next = 1'b0;
      end
    end else if (w_s_fire) begin
      w_load_skid       = 1'b1;
      w_skid_valid_next = 1'b1;
    end
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_out_valid  <= 1'b0;
      r_skid_valid <= 1'b0;
      r_s_ready    <= 1'b0;
      r_out_data   <= '0;
      r_skid_data  <= '0;
    end else begin
      r_out_valid  <= w_out_valid_next;
      r_skid_valid <= w_skid_valid_next;
      r_s_ready    <= !w_skid_valid_next;
      if (w_load_out_from_skid) begin
        r_out_data <= r_skid_data;
      end else if (w_load_out_from_in) begin
        r_out_data <= s_data;
      end
      if (w_load_skid) begin
        r_skid_data <= s_data;
      end
    end
  end

  assign s_ready = r_s_ready;
  assign m_valid = r_out_valid;
  assign m_data  = r_out_data;

endmodule

// File: rtl/axis_route_stamp.sv
// Per-region ingress stage: samples the region route at each packet's first
// beat, checks its destination port against the permission mask, and either
// forwards the packet with a stable route_out or silently absorbs it and
// counts the drop.
// Ports:
//   aclk, aresetn          : clock, synchronous active-low reset
//   cfg_route, cfg_allow   : region route and permitted-port mask
//   data_sink_*            : user stream in (tdata/tkeep/tlast/tid/tvalid/tready)
//   data_src_*             : stream out to the switch
//   route_out              : tdest aligned with data_src
//   drop_cnt, drop_pulse   : saturating drop counter, per-drop pulse
module axis_route_stamp #(
  parameter int N_ID       = axis_route_stamp_pkg::N_REGIONS,
  parameter int ROUTE_BITS = axis_route_stamp_pkg::ROUTE_BITS,
  parameter int DATA_BITS  = 64,
  parameter int ID_BITS    = 6
) (
  input  logic                   aclk,
  input  logic                   aresetn,
  input  logic [ROUTE_BITS-1:0]  cfg_route,
  input  logic [2*N_ID-1:0]      cfg_allow,
  input  logic [DATA_BITS-1:0]   data_sink_tdata,
  input  logic [DATA_BITS/8-1:0] data_sink_tkeep,
  input  logic                   data_sink_tlast,
  input  logic [ID_BITS-1:0]     data_sink_tid,
  input  logic                   data_sink_tvalid,
  output logic                   data_sink_tready,
  output logic [DATA_BITS-1:0]   data_src_tdata,
  output logic [DATA_BITS/8-1:0] data_src_tkeep,
  output logic                   data_src_tlast,
  output logic [ID_BITS-1:0]     data_src_tid,
  output logic                   data_src_tvalid,
  input  logic                   data_src_tready,
  output logic [ROUTE_BITS-1:0]  route_out,
  output logic [31:0]            drop_cnt,
  output logic                   drop_pulse
);

  import axis_route_stamp_pkg::*;

  localparam int KEEP_BITS = DATA_BITS / 8;
  localparam int N_PORTS   = 2 * N_ID;
  localparam int DEST_SPAN = 1 << ROUTE_DEST_BITS;
  localparam int PAY_W     = ROUTE_BITS + ID_BITS + 1 + KEEP_BITS + DATA_BITS;

  stamp_state_t          r_state;
  stamp_state_t          w_state_next;
  logic [ROUTE_BITS-1:0] r_route_q;
  logic                  r_live;
  logic [31:0]           r_drop_cnt;
  logic                  r_drop_pulse;

  logic [DEST_SPAN-1:0]  w_allow_ext;
  logic                  w_first_legal;
  logic [ROUTE_BITS-1:0] w_route_beat;
  logic                  w_fwd;
  logic                  w_sink_ready;
  logic                  w_accept;
  logic                  w_load_route;
  logic                  w_drop_event;
  logic                  w_skid_s_ready;
  logic                  w_skid_m_valid;
  logic [PAY_W-1:0]      w_skid_in;
  logic [PAY_W-1:0]      w_skid_out;

  // Widen the mask to every encodable destination; ports beyond 2*N_ID are
  // never legal, so the lookup alone covers the range check.
  genvar gi;
  generate
    for (gi = 0; gi < DEST_SPAN; gi++) begin : g_allow
      if (gi < N_PORTS) begin : g_port
        assign w_allow_ext[gi] = cfg_allow[gi];
      end else begin : g_none
        assign w_allow_ext[gi] = 1'b0;
      end
    end
  endgenerate

  assign w_first_legal = w_allow_ext[route_dest(cfg_route)];
  assign w_accept      = data_sink_tvalid && w_sink_ready;

  always_comb begin
    w_state_next = r_state;
    w_route_beat = r_route_q;
    w_fwd        = 1'b0;
    w_sink_ready = 1'b0;
    w_load_route = 1'b0;
    w_drop_event = 1'b0;
    case (r_state)
      IDLE: begin
        // First beat uses the live config; it is captured for the rest of the packet.
        w_route_beat = cfg_route;
        if (w_first_legal) begin
          w_fwd        = 1'b1;
          w_sink_ready = w_skid_s_ready;
        end else begin
          // Dropped beats bypass the skid buffer and never wait on the switch.
          w_sink_ready = r_live;
        end
        if (data_sink_tvalid && w_sink_ready) begin
          w_load_route = 1'b1;
          if (!data_sink_tlast) begin
            w_state_next = w_first_legal ? PASS : DROP;
          end else if (!w_first_legal) begin
            w_drop_event = 1'b1;
          end
        end
      end
      PASS: begin
        w_fwd        = 1'b1;
        w_sink_ready = w_skid_s_ready;
        if (w_accept && data_sink_tlast) begin
          w_state_next = IDLE;
        end
      end
      DROP: begin
        w_sink_ready = r_live;
        if (w_accept && data_sink_tlast) begin
          w_state_next = IDLE;
          w_drop_event = 1'b1;
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_state      <= IDLE;
      r_route_q    <= '0;
      r_live       <= 1'b0;
      r_drop_cnt   <= '0;
      r_drop_pulse <= 1'b0;
    end else begin
      r_live       <= 1'b1;
      r_state      <= w_state_next;
      r_drop_pulse <= w_drop_event;
      if (w_load_route) begin
        r_route_q <= cfg_route;
      end
      if (w_drop_event && (r_drop_cnt != 32'hFFFF_FFFF)) begin
        r_drop_cnt <= r_drop_cnt + 32'd1;
      end
    end
  end

  // Route rides as sideband so route_out is always aligned with the output beat.
  assign w_skid_in = {w_route_beat, data_sink_tid, data_sink_tlast,
                      data_sink_tkeep, data_sink_tdata};

  axis_skid_reg #(
    .W(PAY_W)
  ) u_skid (
    .aclk    (aclk),
    .aresetn (aresetn),
    .s_valid (data_sink_tvalid && w_fwd),
    .s_ready (w_skid_s_ready),
    .s_data  (w_skid_in),
    .m_valid (w_skid_m_valid),
    .m_ready (data_src_tready),
    .m_data  (w_skid_out)
  );

  assign data_sink_tready = w_sink_ready;
  assign data_src_tvalid  = w_skid_m_valid;
  assign route_out        = w_skid_out[PAY_W-1 -: ROUTE_BITS];
  assign data_src_tid     = w_skid_out[DATA_BITS+KEEP_BITS+1 +: ID_BITS];
  assign data_src_tlast   = w_skid_out[DATA_BITS+KEEP_BITS];
  assign data_src_tkeep   = w_skid_out[DATA_BITS +: KEEP_BITS];
  assign data_src_tdata   = w_skid_out[DATA_BITS-1:0];
  assign drop_cnt         = r_drop_cnt;
  assign drop_pulse       = r_drop_pulse;

endmodule

// File: tb/tb_axis_route_stamp.sv
// Directed bench for axis_route_stamp: one task per scenario, inline checks.
module tb_axis_route_stamp;

  localparam int N_ID = 6;
  localparam int RB   = 14;
  localparam int DB   = 64;
  localparam int KB   = 8;
  localparam int IB   = 6;

  typedef struct packed {
    logic [RB-1:0] route;
    logic [IB-1:0] id;
    logic          last;
    logic [KB-1:0] keep;
    logic [DB-1:0] data;
  } beat_t;

  logic          aclk = 1'b0;
  logic          aresetn;
  logic [RB-1:0] cfg_route;
  logic [11:0]   cfg_allow;
  logic [DB-1:0] sink_tdata;
  logic [KB-1:0] sink_tkeep;
  logic          sink_tlast;
  logic [IB-1:0] sink_tid;
  logic          sink_tvalid;
  logic          sink_tready;
  logic [DB-1:0] src_tdata;
  logic [KB-1:0] src_tkeep;
  logic          src_tlast;
  logic [IB-1:0] src_tid;
  logic          src_tvalid;
  logic          src_tready;
  logic [RB-1:0] route_out;
  logic [31:0]   drop_cnt;
  logic          drop_pulse;

  always #5 aclk = ~aclk;

  axis_route_stamp #(
    .N_ID(N_ID), .ROUTE_BITS(RB), .DATA_BITS(DB), .ID_BITS(IB)
  ) dut (
    .aclk             (aclk),
    .aresetn          (aresetn),
    .cfg_route        (cfg_route),
    .cfg_allow        (cfg_allow),
    .data_sink_tdata  (sink_tdata),
    .data_sink_tkeep  (sink_tkeep),
    .data_sink_tlast  (sink_tlast),
    .data_sink_tid    (sink_tid),
    .data_sink_tvalid (sink_tvalid),
    .data_sink_tready (sink_tready),
    .data_src_tdata   (src_tdata),
    .data_src_tkeep   (src_tkeep),
    .data_src_tlast   (src_tlast),
    .data_src_tid     (src_tid),
    .data_src_tvalid  (src_tvalid),
    .data_src_tready  (src_tready),
    .route_out        (route_out),
    .drop_cnt         (drop_cnt),
    .drop_pulse       (drop_pulse)
  );

  int    total = 0;
  int    bad = 0;
  int    cyc = 0;
  int    last_waits = 0;
  int    exp_drops = 0;
  int    pulse_cnt = 0;
  int    valid_cycles = 0;
  int    stab_viol = 0;
  logic  bp_mode = 1'b0;
  logic  tready_fixed = 1'b1;
  logic  prev_stall = 1'b0;
  beat_t prev_beat;
  beat_t out_q[$];
  int    out_cyc_q[$];
  int    in_cyc_q[$];

  always @(posedge aclk) cyc <= cyc + 1;

  // Downstream ready: fixed level or ~30% random duty.
  always @(posedge aclk) begin
    #1;
    src_tready <= bp_mode ? ($urandom_range(0, 99) < 30) : tready_fixed;
  end

  // Output monitor: records accepted beats and tracks hold-while-stalled.
  always @(negedge aclk) begin : mon
    beat_t cur;
    cur = {route_out, src_tid, src_tlast, src_tkeep, src_tdata};
    if (aresetn === 1'b1) begin
      if (drop_pulse === 1'b1) pulse_cnt++;
      if (src_tvalid === 1'b1) valid_cycles++;
      if (prev_stall && (src_tvalid !== 1'b1 || cur !== prev_beat)) stab_viol++;
      if (src_tvalid === 1'b1 && src_tready === 1'b1) begin
        out_q.push_back(cur);
        out_cyc_q.push_back(cyc);
      end
      prev_stall = (src_tvalid === 1'b1) && (src_tready !== 1'b1);
      prev_beat  = cur;
    end else begin
      prev_stall = 1'b0;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  function automatic beat_t mk(input int pkt, input int idx, input int n, input logic [13:0] r);
    beat_t b;
    b.route = r;
    b.id    = pkt[5:0];
    b.last  = (idx == n - 1);
    b.keep  = (idx == n - 1) ? 8'h0F : 8'hFF;
    b.data  = {pkt[31:0], idx[31:0]};
    return b;
  endfunction

  function automatic bit exp_legal(input logic [13:0] r, input logic [11:0] a);
    int d;
    d = int'(r[13:10]);
    if (d >= 2 * N_ID) return 1'b0;
    return a[d];
  endfunction

  task automatic idle(input int n);
    repeat (n) @(posedge aclk);
    #1;
  endtask

  task automatic clear_q();
    out_q.delete();
    out_cyc_q.delete();
    in_cyc_q.delete();
  endtask

  task automatic push_beat(input beat_t b);
    int   waits;
    logic acc;
    sink_tdata  = b.data;
    sink_tkeep  = b.keep;
    sink_tlast  = b.last;
    sink_tid    = b.id;
    sink_tvalid = 1'b1;
    waits = 0;
    acc   = 1'b0;
    while (!acc && waits < 300) begin
      @(negedge aclk);
      acc = (sink_tready === 1'b1);
      if (acc) in_cyc_q.push_back(cyc);
      @(posedge aclk);
      #1;
      waits++;
    end
    sink_tvalid = 1'b0;
    last_waits  = waits;
    if (!acc) begin
      total++;
      bad++;
      $display("FAIL push_timeout beat data=%h not accepted within %0d cycles", b.data, waits);
    end
  endtask

  task automatic push_pkt(input int pkt, input int n, input logic [13:0] r, input logic [11:0] a);
    cfg_route = r;
    cfg_allow = a;
    for (int i = 0; i < n; i++) push_beat(mk(pkt, i, n, r));
  endtask

  task automatic test_reset();
    aresetn     = 1'b0;
    sink_tvalid = 1'b0;
    sink_tdata  = '0;
    sink_tkeep  = '0;
    sink_tlast  = 1'b0;
    sink_tid    = '0;
    cfg_route   = '0;
    cfg_allow   = '0;
    repeat (3) @(posedge aclk);
    @(negedge aclk);
    total++; if (src_tvalid !== 1'b0) begin bad++; $display("FAIL reset_src_tvalid got=%b want=0", src_tvalid); end
    total++; if (sink_tready !== 1'b0) begin bad++; $display("FAIL reset_sink_tready got=%b want=0", sink_tready); end
    total++; if (route_out !== 14'h0) begin bad++; $display("FAIL reset_route_out got=%h want=0", route_out); end
    total++; if (drop_cnt !== 32'h0) begin bad++; $display("FAIL reset_drop_cnt got=%0d want=0", drop_cnt); end
    total++; if (drop_pulse !== 1'b0) begin bad++; $display("FAIL reset_drop_pulse got=%b want=0", drop_pulse); end
    @(posedge aclk);
    #1;
    aresetn = 1'b1;
    @(posedge aclk);
    @(negedge aclk);
    total++; if (sink_tready !== 1'b1) begin bad++; $display("FAIL post_reset_sink_tready got=%b want=1", sink_tready); end
    total++; if (src_tvalid !== 1'b0) begin bad++; $display("FAIL post_reset_src_tvalid got=%b want=0", src_tvalid); end
    @(posedge aclk);
    #1;
    $display("test_reset done");
  endtask

  task automatic test_legal_single();
    beat_t e;
    tready_fixed = 1'b1;
    idle(2);
    clear_q();
    push_pkt(1, 4, 14'h0800, 12'h004);
    idle(4);
    total++; if (out_q.size() != 4) begin bad++; $display("FAIL legal_count got=%0d want=4", out_q.size()); end
    for (int i = 0; i < 4 && i < out_q.size(); i++) begin
      e = mk(1, i, 4, 14'h0800);
      total++; if (out_q[i] !== e) begin bad++; $display("FAIL legal_beat%0d got=%h want=%h", i, out_q[i], e); end
      total++; if (out_cyc_q[i] - in_cyc_q[i] != 1) begin bad++; $display("FAIL legal_latency%0d got=%0d want=1", i, out_cyc_q[i] - in_cyc_q[i]); end
    end
    total++; if (in_cyc_q.size() == 4 && in_cyc_q[3] - in_cyc_q[0] != 3) begin bad++; $display("FAIL legal_throughput span got=%0d want=3", in_cyc_q[3] - in_cyc_q[0]); end
    total++; if (drop_cnt !== 32'd0) begin bad++; $display("FAIL legal_drop_cnt got=%0d want=0", drop_cnt); end
    $display("test_legal_single done: beats=%0d", out_q.size());
  endtask

  task automatic test_illegal_port();
    int v0, p0;
    logic [13:0] r;
    r = {4'd12, 10'h155};
    tready_fixed = 1'b0;
    idle(2);
    clear_q();
    v0 = valid_cycles;
    p0 = pulse_cnt;
    cfg_route = r;
    cfg_allow = 12'hFFF;
    for (int i = 0; i < 3; i++) begin
      push_beat(mk(2, i, 3, r));
      total++; if (last_waits != 1) begin bad++; $display("FAIL illegal_ready beat%0d waits got=%0d want=1", i, last_waits); end
    end
    exp_drops++;
    idle(3);
    total++; if (valid_cycles != v0) begin bad++; $display("FAIL illegal_src_valid cycles got=%0d want=0", valid_cycles - v0); end
    total++; if (drop_cnt !== exp_drops) begin bad++; $display("FAIL illegal_drop_cnt got=%0d want=%0d", drop_cnt, exp_drops); end
    total++; if (pulse_cnt - p0 != 1) begin bad++; $display("FAIL illegal_pulses got=%0d want=1", pulse_cnt - p0); end
    tready_fixed = 1'b1;
    idle(2);
    $display("test_illegal_port done: drop_cnt=%0d", drop_cnt);
  endtask

  task automatic test_mask_deny_allow();
    beat_t e;
    logic [13:0] r;
    r = {4'd3, 10'h0AA};
    clear_q();
    push_pkt(3, 2, r, 12'hFF7);
    exp_drops++;
    push_pkt(4, 3, r, 12'h008);
    idle(4);
    total++; if (drop_cnt !== exp_drops) begin bad++; $display("FAIL mask_drop_cnt got=%0d want=%0d", drop_cnt, exp_drops); end
    total++; if (out_q.size() != 3) begin bad++; $display("FAIL mask_count got=%0d want=3", out_q.size()); end
    for (int i = 0; i < 3 && i < out_q.size(); i++) begin
      e = mk(4, i, 3, r);
      total++; if (out_q[i] !== e) begin bad++; $display("FAIL mask_beat%0d got=%h want=%h", i, out_q[i], e); end
    end
    $display("test_mask_deny_allow done: beats=%0d", out_q.size());
  endtask

  task automatic test_midpacket_cfg();
    beat_t e;
    logic [13:0] r1, r5;
    r1 = {4'd1, 10'h011};
    r5 = {4'd5, 10'h055};
    clear_q();
    cfg_route = r1;
    cfg_allow = 12'hFFF;
    for (int i = 0; i < 8; i++) begin
      if (i == 2) cfg_route = r5;
      if (i == 4) cfg_allow = 12'h000;
      push_beat(mk(5, i, 8, r1));
    end
    push_pkt(6, 2, r5, 12'hFFF);
    idle(4);
    total++; if (out_q.size() != 10) begin bad++; $display("FAIL midcfg_count got=%0d want=10", out_q.size()); end
    for (int i = 0; i < 10 && i < out_q.size(); i++) begin
      e = (i < 8) ? mk(5, i, 8, r1) : mk(6, i - 8, 2, r5);
      total++; if (out_q[i] !== e) begin bad++; $display("FAIL midcfg_beat%0d got=%h want=%h", i, out_q[i], e); end
    end
    $display("test_midpacket_cfg done: beats=%0d", out_q.size());
  endtask

  task automatic test_back_to_back();
    beat_t exp_b[$];
    clear_q();
    push_pkt(7, 2, {4'd0, 10'h3FF}, 12'h001);
    push_pkt(8, 1, {4'd11, 10'h001}, 12'h001);
    exp_drops++;
    push_pkt(9, 1, {4'd11, 10'h002}, 12'h800);
    push_pkt(10, 3, {4'd15, 10'h0F0}, 12'hFFF);
    exp_drops++;
    push_pkt(11, 1, {4'd0, 10'h00C}, 12'h001);
    idle(4);
    exp_b.push_back(mk(7, 0, 2, {4'd0, 10'h3FF}));
    exp_b.push_back(mk(7, 1, 2, {4'd0, 10'h3FF}));
    exp_b.push_back(mk(9, 0, 1, {4'd11, 10'h002}));
    exp_b.push_back(mk(11, 0, 1, {4'd0, 10'h00C}));
    total++; if (in_cyc_q.size() != 8 || in_cyc_q[7] - in_cyc_q[0] != 7) begin bad++; $display("FAIL b2b_bubble accepted=%0d want 8 beats in 8 consecutive cycles", in_cyc_q.size()); end
    total++; if (out_q.size() != 4) begin bad++; $display("FAIL b2b_count got=%0d want=4", out_q.size()); end
    for (int i = 0; i < 4 && i < out_q.size(); i++) begin
      total++; if (out_q[i] !== exp_b[i]) begin bad++; $display("FAIL b2b_beat%0d got=%h want=%h", i, out_q[i], exp_b[i]); end
    end
    total++; if (drop_cnt !== exp_drops) begin bad++; $display("FAIL b2b_drop_cnt got=%0d want=%0d", drop_cnt, exp_drops); end
    $display("test_back_to_back done: beats=%0d drops=%0d", out_q.size(), drop_cnt);
  endtask

  task automatic test_random_backpressure();
    beat_t exp_q[$];
    int n, dest, n_ill, p0, s0, w;
    logic [13:0] r;
    logic [11:0] a;
    clear_q();
    n_ill = 0;
    p0 = pulse_cnt;
    s0 = stab_viol;
    bp_mode = 1'b1;
    for (int p = 0; p < 200; p++) begin
      n    = $urandom_range(1, 16);
      dest = $urandom_range(0, 15);
      r    = {dest[3:0], 10'($urandom)};
      a    = 12'($urandom);
      if (exp_legal(r, a)) begin
        for (int i = 0; i < n; i++) exp_q.push_back(mk(100 + p, i, n, r));
      end else begin
        n_ill++;
        exp_drops++;
      end
      push_pkt(100 + p, n, r, a);
      if ($urandom_range(0, 3) == 0) idle(1);
    end
    w = 0;
    while (out_q.size() < exp_q.size() && w < 3000) begin
      idle(1);
      w++;
    end
    bp_mode = 1'b0;
    idle(3);
    total++; if (out_q.size() != exp_q.size()) begin bad++; $display("FAIL rand_count got=%0d want=%0d", out_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < out_q.size(); i++) begin
      total++; if (out_q[i] !== exp_q[i]) begin bad++; $display("FAIL rand_beat%0d got=%h want=%h", i, out_q[i], exp_q[i]); end
    end
    total++; if (drop_cnt !== exp_drops) begin bad++; $display("FAIL rand_drop_cnt got=%0d want=%0d", drop_cnt, exp_drops); end
    total++; if (pulse_cnt - p0 != n_ill) begin bad++; $display("FAIL rand_pulses got=%0d want=%0d", pulse_cnt - p0, n_ill); end
    total++; if (stab_viol != s0) begin bad++; $display("FAIL rand_stall_stability violations got=%0d want=0", stab_viol - s0); end
    $display("test_random_backpressure done: legal_beats=%0d illegal_pkts=%0d", exp_q.size(), n_ill);
  endtask

  task automatic test_reset_midpacket();
    beat_t e;
    logic [13:0] r, r2;
    r  = {4'd2, 10'h123};
    r2 = {4'd7, 10'h2AA};
    tready_fixed = 1'b1;
    idle(2);
    clear_q();
    cfg_route = r;
    cfg_allow = 12'hFFF;
    for (int i = 0; i < 3; i++) push_beat(mk(20, i, 6, r));
    e = mk(20, 3, 6, r);
    sink_tdata  = e.data;
    sink_tkeep  = e.keep;
    sink_tlast  = e.last;
    sink_tid    = e.id;
    sink_tvalid = 1'b1;
    aresetn     = 1'b0;
    @(posedge aclk);
    @(negedge aclk);
    total++; if (src_tvalid !== 1'b0) begin bad++; $display("FAIL midrst_src_tvalid got=%b want=0", src_tvalid); end
    total++; if (sink_tready !== 1'b0) begin bad++; $display("FAIL midrst_sink_tready got=%b want=0", sink_tready); end
    total++; if (route_out !== 14'h0) begin bad++; $display("FAIL midrst_route_out got=%h want=0", route_out); end
    total++; if (drop_cnt !== 32'h0) begin bad++; $display("FAIL midrst_drop_cnt got=%0d want=0", drop_cnt); end
    total++; if (drop_pulse !== 1'b0) begin bad++; $display("FAIL midrst_drop_pulse got=%b want=0", drop_pulse); end
    exp_drops = 0;
    @(posedge aclk);
    #1;
    sink_tvalid = 1'b0;
    aresetn     = 1'b1;
    idle(1);
    clear_q();
    push_pkt(21, 2, r2, 12'h080);
    idle(4);
    total++; if (out_q.size() != 2) begin bad++; $display("FAIL midrst_count got=%0d want=2", out_q.size()); end
    for (int i = 0; i < 2 && i < out_q.size(); i++) begin
      e = mk(21, i, 2, r2);
      total++; if (out_q[i] !== e) begin bad++; $display("FAIL midrst_beat%0d got=%h want=%h", i, out_q[i], e); end
    end
    $display("test_reset_midpacket done: beats=%0d", out_q.size());
  endtask

  initial begin
    test_reset();
    test_legal_single();
    test_illegal_port();
    test_mask_deny_allow();
    test_midpacket_cfg();
    test_back_to_back();
    test_random_backpressure();
    test_reset_midpacket();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
